// File: rtl/sobel5_win_ctrl.sv
// sobel5_win_ctrl: raster-to-column sequencer for the NxN Sobel conv stage,
// with line buffers and result valid/sof/eol tracking aligned to conv dout.
module sobel5_win_ctrl #(
    parameter int N        = 5,
    parameter int DW       = 9,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int CONV_LAT = 6,
    parameter int CW       = 10,
    parameter int RW       = 9
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            pix_vld,
    input  logic            pix_sof,
    input  logic            pix_eol,
    input  logic [DW-1:0]   pix,
    output logic [N*DW-1:0] col_dout,
    output logic            col_vld,
    output logic            out_vld,
    output logic            out_sof,
    output logic            out_eol,
    output logic            frm_err,
    output logic            busy
);
    localparam int PL = CONV_LAT + 1;
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d, pc;
    logic [RW-1:0]     row_q, row_d, pr;
    logic [SW-1:0]     sup_q, sup_d, sup_e;
    logic              gap_q, gap_d, err_q, err_d, col_vld_q;
    logic [PL-1:0]     vp_q, vp_d, sp_q, sp_d, ep_q, ep_d;
    logic [N*DW-1:0]   col_dout_q, col_dout_d, col_rd;
    logic              acc, eol_e, last_row, win_ok, gap;
    logic [AW-1:0]     adr;

    // Buffer g holds row r-(N-1)+g; each accepted pixel shifts its column up one buffer.
    assign col_rd[(N-1)*DW +: DW] = pix;
    for (genvar g = 0; g < N-1; g++) begin : g_lb
        logic [DW-1:0] mem [IMG_W];
        always_ff @(posedge clk)
            if (acc) mem[adr] <= col_rd[(g+1)*DW +: DW];
        assign col_rd[g*DW +: DW] = mem[adr];
    end

    always_comb begin
        acc      = pix_vld && (pix_sof || state_q == ACTIVE);
        pc       = pix_sof ? '0 : col_q;
        pr       = pix_sof ? '0 : row_q;
        sup_e    = pix_sof ? '0 : sup_q;
        adr      = pc[AW-1:0];
        eol_e    = pix_eol || pc == CW'(IMG_W-1);
        last_row = pr == RW'(IMG_H-1);
        win_ok   = pr >= RW'(N-1) && pc >= CW'(N-1) && sup_e == '0;
        gap      = !pix_vld && state_q == ACTIVE && col_q != '0 && !gap_q;
        err_d    = gap || (pix_vld && pix_sof && state_q == ACTIVE) ||
                   (acc && (pix_eol != (pc == CW'(IMG_W-1)))) ||
                   (pix_vld && !pix_sof && state_q == DRAIN);
        state_d  = acc ? ((eol_e && last_row) ? DRAIN : ACTIVE) :
                   ((state_q == DRAIN && vp_q == '0) ? IDLE : state_q);
        col_d    = acc ? (eol_e ? '0 : pc + 1'b1) : col_q;
        row_d    = acc ? (eol_e ? (last_row ? '0 : pr + 1'b1) : pr) : row_q;
        gap_d    = acc ? 1'b0 : (gap_q || gap);
        // The conv shift registers keep running through a gap, so the next N-1 columns are stale.
        sup_d    = gap ? SW'(N-1) :
                   acc ? (eol_e ? '0 : sup_e - SW'(sup_e != '0)) : sup_q;
        vp_d     = {vp_q[PL-2:0], acc && win_ok};
        sp_d     = {sp_q[PL-2:0], acc && win_ok && pr == RW'(N-1) && pc == CW'(N-1)};
        ep_d     = {ep_q[PL-2:0], acc && win_ok && pc == CW'(IMG_W-1)};
        col_dout_d = pix_vld ? col_rd : col_dout_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            sup_q      <= '0;
            gap_q      <= 1'b0;
            err_q      <= 1'b0;
            col_vld_q  <= 1'b0;
            col_dout_q <= '0;
            vp_q       <= '0;
            sp_q       <= '0;
            ep_q       <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            sup_q      <= sup_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            col_vld_q  <= pix_vld;
            col_dout_q <= col_dout_d;
            vp_q       <= vp_d;
            sp_q       <= sp_d;
            ep_q       <= ep_d;
        end
    end

    assign col_dout = col_dout_q;
    assign col_vld  = col_vld_q;
    assign out_vld  = vp_q[PL-1];
    assign out_sof  = sp_q[PL-1];
    assign out_eol  = ep_q[PL-1];
    assign frm_err  = err_q;
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_sobel5_win_ctrl.sv
// tb_sobel5_win_ctrl: directed frame scenarios with random pixel data, checked cycle by
// cycle against expectations derived from frame position, gaps and framing errors.
module tb_sobel5_win_ctrl;
    localparam int N = 5, DW = 9, W = 8, H = 6, LAT = 6, M = 4096;

    logic            clk = 1'b0, rst_b = 1'b0, pix_vld = 1'b0, pix_sof = 1'b0, pix_eol = 1'b0;
    logic [DW-1:0]   pix = '0;
    logic [N*DW-1:0] col_dout;
    logic            col_vld, out_vld, out_sof, out_eol, frm_err, busy;

    int checks = 0, failures = 0, s = 0, nres = 0, sup = 0;
    bit ev[M], es[M], ee[M], ecv[M], eerr[M], ecc[M];
    logic [N*DW-1:0] ecol[M];
    logic [DW-1:0]   img[H][W];
    bit              wr[H][W];

    sobel5_win_ctrl #(.N(N), .DW(DW), .IMG_W(W), .IMG_H(H), .CONV_LAT(LAT), .CW(10), .RW(9)) dut (
        .clk(clk), .rst_b(rst_b), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix(pix), .col_dout(col_dout), .col_vld(col_vld), .out_vld(out_vld),
        .out_sof(out_sof), .out_eol(out_eol), .frm_err(frm_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s at step %0d: observed=%0h expected=%0h", tag, s, obs, expv);
        end
    endtask

    // Checks the outputs for the current cycle, then applies the next input.
    task automatic step(input bit v, input bit sf, input bit el, input logic [DW-1:0] p);
        @(negedge clk);
        chk("col_vld", 64'(col_vld), 64'(ecv[s]));
        chk("out_vld", 64'(out_vld), 64'(ev[s]));
        chk("out_sof", 64'(out_sof), 64'(es[s]));
        chk("out_eol", 64'(out_eol), 64'(ee[s]));
        chk("frm_err", 64'(frm_err), 64'(eerr[s]));
        if (ecc[s]) chk("col_dout", 64'(col_dout), 64'(ecol[s]));
        if (out_vld) nres++;
        pix_vld = v; pix_sof = sf; pix_eol = el; pix = p;
        ecv[s+1] = v;
        s++;
    endtask

    task automatic idle(input int n, input bit gap_err);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            if (gap_err && i == 0) begin
                eerr[s] = 1'b1;
                sup = N - 1;
            end
        end
    endtask

    task automatic px(input int r, input int c, input bit sf, input bit el, input bit err);
        logic [DW-1:0] p;
        bit ok, full;
        p = DW'($urandom);
        step(1'b1, sf, el, p);
        if (!sf) chk("busy_frame", 64'(busy), 64'd1);
        if (sf) begin
            for (int i = 0; i < H; i++)
                for (int j = 0; j < W; j++) wr[i][j] = 1'b0;
            sup = 0;
        end
        img[r][c] = p;
        wr[r][c] = 1'b1;
        ok = r >= N-1 && c >= N-1 && sup == 0;
        if (sup > 0) sup--;
        if (el || c == W-1) sup = 0;
        ev[s+LAT] = ok;
        es[s+LAT] = ok && r == N-1 && c == N-1;
        ee[s+LAT] = ok && c == W-1;
        eerr[s] = err;
        if (r >= N-1) begin
            full = 1'b1;
            for (int i = 0; i < N; i++) begin
                full = full && wr[r-(N-1)+i][c];
                ecol[s][i*DW +: DW] = img[r-(N-1)+i][c];
            end
            ecc[s] = full;
        end
    endtask

    // mode: 0 continuous, 1 ten-cycle blanking, 2 mid-row gap, 3 early eol, 4 random blanking
    task automatic frame(input int mode, input int stop_r, input bit abandon);
        int lc;
        for (int r = 0; r < H; r++) begin
            lc = (mode == 3 && r == 2) ? 5 : W - 1;
            for (int c = 0; c <= lc; c++) begin
                if (r == stop_r && c == 6) return;
                if (mode == 2 && r == 4 && c == 6) idle(1, 1'b1);
                px(r, c, r == 0 && c == 0, c == lc,
                   (mode == 3 && r == 2 && c == 5) || (abandon && r == 0 && c == 0));
            end
            if (r < H-1) idle(mode == 1 ? 10 : mode == 4 ? int'($urandom_range(0, 3)) : 0, 1'b0);
        end
    endtask

    task automatic finish_frame(input int expected);
        idle(12, 1'b0);
        chk("result_count", 64'(nres), 64'(expected));
        chk("busy_idle", 64'(busy), 64'd0);
        nres = 0;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, '0);
        rst_b = 1'b0;
        #1;
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_sof", 64'(out_sof), 64'd0);
        chk("rst_out_eol", 64'(out_eol), 64'd0);
        chk("rst_frm_err", 64'(frm_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_col_vld", 64'(col_vld), 64'd0);
        chk("rst_col_dout", 64'(col_dout), 64'd0);
        for (int i = s; i < M; i++) begin
            ev[i] = 0; es[i] = 0; ee[i] = 0; ecv[i] = 0; eerr[i] = 0; ecc[i] = 0;
        end
        idle(2, 1'b0);
        rst_b = 1'b1;
        nres = 0;
    endtask

    initial begin
        idle(2, 1'b0);
        chk("init_col_dout", 64'(col_dout), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        rst_b = 1'b1;
        idle(2, 1'b0);
        frame(0, -1, 1'b0);
        finish_frame(8);
        frame(1, -1, 1'b0);
        finish_frame(8);
        frame(2, -1, 1'b0);
        finish_frame(6);
        frame(3, -1, 1'b0);
        step(1'b1, 1'b0, 1'b0, DW'($urandom));
        eerr[s] = 1'b1;
        finish_frame(8);
        frame(0, -1, 1'b0);
        frame(4, -1, 1'b0);
        finish_frame(16);
        frame(0, 2, 1'b0);
        frame(0, -1, 1'b1);
        finish_frame(8);
        frame(0, 4, 1'b0);
        do_reset();
        frame(0, -1, 1'b0);
        finish_frame(8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
